// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB arbiter: one-hot HGRANT, registered HMASTER/HMASTLOCK.
// Fixed-length bursts and HLOCK hold the grant until the final beat is accepted.
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int MASTER_ID_WIDTH = 2,
  parameter int DEFAULT_MASTER  = 0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [NUM_MASTERS-1:0]     HBUSREQ,
  input  logic [NUM_MASTERS-1:0]     HLOCK,
  input  logic [1:0]                 HTRANS,
  input  logic [2:0]                 HBURST,
  input  logic                       HREADY,
  output logic [NUM_MASTERS-1:0]     HGRANT,
  output logic [MASTER_ID_WIDTH-1:0] HMASTER,
  output logic                       HMASTLOCK
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam logic [IDX_W-1:0]       DEF_IDX   = IDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nxt;
  logic [IDX_W-1:0]       r_last;
  logic [IDX_W-1:0]       w_gidx;
  logic [IDX_W-1:0]       w_winner;
  logic [IDX_W-1:0]       w_cand;
  logic                   w_locked;
  logic                   w_arb_en;
  logic [NUM_MASTERS-1:0] r_hgrant;
  logic [MASTER_ID_WIDTH-1:0] r_hmaster;
  logic                   r_hmastlock;

  // Index reached by stepping off positions forward from base, wrapping at NUM_MASTERS.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_MASTERS) sum = sum - NUM_MASTERS;
    return IDX_W'(sum);
  endfunction

  // Remaining beats after the beat accepted at this edge.
  always_comb begin
    // NOTE: assign the default first so every path drives w_cnt_nxt; otherwise a latch is inferred.
    w_cnt_nxt = r_cnt;
    if (HREADY) begin
      unique case (htrans_e'(HTRANS))
        TR_NONSEQ: begin
          case (HBURST)
            3'b010, 3'b011: w_cnt_nxt = 4'd3;
            3'b100, 3'b101: w_cnt_nxt = 4'd7;
            3'b110, 3'b111: w_cnt_nxt = 4'd15;
            default:        w_cnt_nxt = 4'd0;
          endcase
        end
        TR_SEQ:  w_cnt_nxt = (r_cnt != 4'd0) ? r_cnt - 4'd1 : 4'd0;
        TR_IDLE: w_cnt_nxt = 4'd0;
        TR_BUSY: w_cnt_nxt = r_cnt;
      endcase
    end
  end

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_hgrant[i]) w_gidx = IDX_W'(i);
    end
  end

  // Scan from farthest to nearest so the nearest requester after r_last wins.
  always_comb begin
    w_winner = DEF_IDX;
    w_cand   = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      w_cand = rr_idx(r_last, k);
      if (HBUSREQ[w_cand]) w_winner = w_cand;
    end
  end

  assign w_locked = HLOCK[w_gidx] & HBUSREQ[w_gidx];
  assign w_arb_en = HREADY && (w_cnt_nxt == 4'd0) && !w_locked;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt       <= '0;
      r_last      <= DEF_IDX;
      r_hgrant    <= DEF_GRANT;
      r_hmaster   <= MASTER_ID_WIDTH'(DEFAULT_MASTER);
      r_hmastlock <= 1'b0;
    end else begin
      // NOTE: non-blocking so ownership below samples the grant from before this edge.
      r_cnt <= w_cnt_nxt;
      if (w_arb_en) begin
        r_hgrant <= NUM_MASTERS'(1) << w_winner;
        if (|HBUSREQ) r_last <= w_winner;
      end
      if (HREADY) begin
        r_hmaster   <= MASTER_ID_WIDTH'(w_gidx);
        r_hmastlock <= HLOCK[w_gidx];
      end
    end
  end

  assign HGRANT    = r_hgrant;
  assign HMASTER   = r_hmaster;
  assign HMASTLOCK = r_hmastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_ahb_bus_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int DEF = 0;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011, INCR8 = 3'b101, INCR16 = 3'b111;

  logic           HCLK = 1'b0;
  logic           HRESETn = 1'b0;
  logic [N-1:0]   HBUSREQ = '0;
  logic [N-1:0]   HLOCK = '0;
  logic [1:0]     HTRANS = IDLE;
  logic [2:0]     HBURST = SINGLE;
  logic           HREADY = 1'b1;
  logic [N-1:0]   HGRANT;
  logic [IDW-1:0] HMASTER;
  logic           HMASTLOCK;

  ahb_bus_arbiter #(.NUM_MASTERS(N), .MASTER_ID_WIDTH(IDW), .DEFAULT_MASTER(DEF)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: beats left in the burst, owner/grant as plain indices.
  int m_cnt = 0, m_last = DEF, m_gnt = DEF, m_own = DEF;
  bit m_mlock = 1'b0;
  int m_nxt, m_idx;

  function automatic int burst_beats(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_cnt = 0; m_last = DEF; m_gnt = DEF; m_own = DEF; m_mlock = 1'b0;
    end else begin
      m_nxt = m_cnt;
      if (HREADY) begin
        if (HTRANS == NONSEQ)    m_nxt = burst_beats(HBURST) - 1;
        else if (HTRANS == SEQ)  m_nxt = (m_cnt > 0) ? m_cnt - 1 : 0;
        else if (HTRANS == IDLE) m_nxt = 0;
        m_own   = m_gnt;
        m_mlock = HLOCK[m_gnt[1:0]];
      end
      if (HREADY && m_nxt == 0 && !(HLOCK[m_gnt[1:0]] && HBUSREQ[m_gnt[1:0]])) begin
        if (HBUSREQ == '0) m_gnt = DEF;
        else begin
          for (int k = 1; k <= N; k++) begin
            m_idx = (m_last + k) % N;
            if (HBUSREQ[m_idx[1:0]]) begin
              m_gnt  = m_idx;
              m_last = m_idx;
              break;
            end
          end
        end
      end
      m_cnt = m_nxt;
    end
  end

  always @(negedge HCLK) begin
    if (cmp_en) begin
      check("grant_vs_model", 32'(HGRANT), 32'(1) << m_gnt);
      check("hmaster_vs_model", 32'(HMASTER), 32'(m_own));
      check("hmastlock_vs_model", 32'(HMASTLOCK), 32'(m_mlock));
      check("grant_onehot", 32'($onehot(HGRANT)), 32'd1);
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HBUSREQ = '0; HLOCK = '0; HTRANS = IDLE; HBURST = SINGLE; HREADY = 1'b1;
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    cmp_en = 1'b1;

    // Idle after reset: default master owns the bus.
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_grant", 32'(HGRANT), 32'h1);
      check("rst_master", 32'(HMASTER), 32'h0);
      check("rst_mlock", 32'(HMASTLOCK), 32'h0);
    end

    // INCR4 from M0 with M1 waiting.
    HBUSREQ = 4'b0011; HTRANS = NONSEQ; HBURST = INCR4;
    step(); check("incr4_b1_grant", 32'(HGRANT), 32'h1);
    HTRANS = SEQ;
    step(); check("incr4_b2_grant", 32'(HGRANT), 32'h1);
    step(); check("incr4_b3_grant", 32'(HGRANT), 32'h1);
    step(); check("incr4_b4_grant", 32'(HGRANT), 32'h2);
    check("incr4_b4_master", 32'(HMASTER), 32'h0);
    HTRANS = IDLE;
    step(); check("incr4_owner", 32'(HMASTER), 32'h1);

    // INCR8 with a BUSY and two wait states on beat 5.
    do_reset();
    HBUSREQ = 4'b0011; HBURST = INCR8;
    for (int i = 0; i < 11; i++) begin
      HTRANS = (i == 0) ? NONSEQ : (i == 2) ? BUSY : SEQ;
      HREADY = !(i == 5 || i == 6);
      step();
      check($sformatf("incr8_step%0d_grant", i), 32'(HGRANT), (i == 10) ? 32'h2 : 32'h1);
    end
    HREADY = 1'b1; HTRANS = IDLE;

    // All masters issuing SINGLE: grant rotates every edge.
    do_reset();
    HBUSREQ = 4'b1111; HTRANS = NONSEQ; HBURST = SINGLE;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("rr_%0d_grant", i), 32'(HGRANT), 32'(1) << ((i + 1) % 4));
      check($sformatf("rr_%0d_master", i), 32'(HMASTER), 32'(i % 4));
    end

    // M2 locked across two INCR4 bursts.
    do_reset();
    HBUSREQ = 4'b0100; HLOCK = 4'b0100; HTRANS = IDLE;
    step(); check("lock_initial_grant", 32'(HGRANT), 32'h4);
    HBUSREQ = 4'b1111; HBURST = INCR4;
    for (int i = 0; i < 8; i++) begin
      HTRANS = (i % 4 == 0) ? NONSEQ : SEQ;
      step();
      check($sformatf("lock_b%0d_grant", i), 32'(HGRANT), 32'h4);
      check($sformatf("lock_b%0d_master", i), 32'(HMASTER), 32'h2);
      check($sformatf("lock_b%0d_mlock", i), 32'(HMASTLOCK), 32'h1);
    end
    HLOCK = 4'b0000; HTRANS = IDLE;
    step(); check("unlock_grant", 32'(HGRANT), 32'h8);
    check("unlock_mlock", 32'(HMASTLOCK), 32'h0);

    // M1 aborts INCR16 with IDLE after 5 beats.
    do_reset();
    HBUSREQ = 4'b0010;
    step(); check("abort_pre_grant", 32'(HGRANT), 32'h2);
    HBUSREQ = 4'b0011; HBURST = INCR16;
    for (int i = 0; i < 5; i++) begin
      HTRANS = (i == 0) ? NONSEQ : SEQ;
      step();
      check($sformatf("abort_b%0d_grant", i), 32'(HGRANT), 32'h2);
    end
    HTRANS = IDLE;
    step(); check("abort_grant", 32'(HGRANT), 32'h1);

    // Asynchronous reset in the middle of an INCR8 owned by M1.
    do_reset();
    HBUSREQ = 4'b0010;
    step();
    HTRANS = NONSEQ; HBURST = INCR8;
    step();
    HTRANS = SEQ;
    step();
    check("arst_pre_master", 32'(HMASTER), 32'h1);
    #2 HRESETn = 1'b0;
    #1;
    check("arst_grant", 32'(HGRANT), 32'h1);
    check("arst_master", 32'(HMASTER), 32'h0);
    check("arst_mlock", 32'(HMASTLOCK), 32'h0);
    HTRANS = IDLE;
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    step(); check("arst_rearb_grant", 32'(HGRANT), 32'h2);

    // Randomized traffic, checked by the compare process.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      HBUSREQ = N'($urandom);
      HLOCK   = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      r = $urandom_range(0, 9);
      HTRANS  = (r == 0) ? IDLE : (r == 1) ? BUSY : (r < 4) ? NONSEQ : SEQ;
      HBURST  = 3'($urandom);
      HREADY  = ($urandom_range(0, 4) != 0);
      step();
    end

    @(negedge HCLK);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin AHB bus arbiter that shares the single AHB address/data path between NUM_MASTERS burst-generating masters.
- It drives HGRANT and HMASTER and tracks beats of fixed-length bursts (INCR4/8/16, WRAP4/8/16) so that ownership never changes mid-burst.
- It honours HLOCK and HREADY.
- It sits between the master traffic generators and the shared address-phase mux feeding the slave/bridge.

Parameters:
- NUM_MASTERS, 4: number of requesting masters, 2..16.
- MASTER_ID_WIDTH, 2: width of HMASTER; must be at least clog2(NUM_MASTERS).
- DEFAULT_MASTER, 0: master granted when no HBUSREQ is asserted; also the reset owner.

Ports:
- HCLK, input, 1: bus clock; all state updates on its rising edge.
- HRESETn, input, 1: reset, asynchronous, active-low.
- HBUSREQ, input, NUM_MASTERS: per-master bus request.
- HLOCK, input, NUM_MASTERS: per-master locked-transfer request.
- HTRANS, input, 2: muxed HTRANS of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HBURST, input, 3: muxed HBURST of the current owner (000 SINGLE, 001 INCR, 010 WRAP4, 011 INCR4, 100 WRAP8, 101 INCR8, 110 WRAP16, 111 INCR16).
- HREADY, input, 1: shared transfer-done from the slave side.
- HGRANT, output, NUM_MASTERS: one-hot grant, registered.
- HMASTER, output, MASTER_ID_WIDTH: index of the current address-phase owner, registered.
- HMASTLOCK, output, 1: current address phase is locked, registered.

Behaviour:
- Reset (HRESETn low, asynchronous):
  - HGRANT = one-hot(DEFAULT_MASTER); HMASTER = DEFAULT_MASTER; HMASTLOCK = 0.
  - Beat counter cnt = 0; round-robin pointer last = DEFAULT_MASTER.
  - Reset mid-burst abandons the burst immediately; no pending state survives.
- accept = HREADY && (HTRANS == NONSEQ || HTRANS == SEQ).

Beat counter (4 bits, remaining beats after the one just accepted), updated on each edge:
- accept of NONSEQ: load 3 for WRAP4/INCR4, 7 for WRAP8/INCR8, 15 for WRAP16/INCR16, 0 for SINGLE/INCR.
- accept of SEQ with cnt > 0: cnt - 1.
- accept of SEQ with cnt == 0 (INCR undefined length): stays 0.
- HREADY && HTRANS == IDLE: cnt = 0 (early burst termination).
- HTRANS == BUSY, or HREADY low: cnt holds.
- A NONSEQ accepted while cnt > 0 aborts the old burst and reloads for the new one.
- cnt_nxt is the value cnt takes at the current edge.

Arbitration point (arb_en) = HREADY && cnt_nxt == 0 && !(HLOCK[g] && HBUSREQ[g]), where g = currently granted index.
- When arb_en is low, HGRANT holds.
- When arb_en is high, HGRANT is updated at the edge to the first requester searching last+1, last+2, ... wrapping modulo NUM_MASTERS; last is updated to the winner.
- If no HBUSREQ is set, grant goes to DEFAULT_MASTER and last is not changed.
- If g is the only requester, the grant stays on g.
- Undefined-length INCR and SINGLE are re-arbitrable at every HREADY edge.
- A fixed burst is re-arbitrable only at the edge accepting its final beat.

Locking:
- While the granted master holds HLOCK and HBUSREQ, the grant is frozen across burst ends.
- The lock releases on the first arb_en edge after HLOCK drops.

Ownership:
- At each edge with HREADY high, HMASTER <= index of HGRANT (value before that edge) and HMASTLOCK <= HLOCK[that index].
- With HREADY low, HMASTER and HMASTLOCK hold.
- Result: a grant change becomes ownership at the next HREADY edge, giving a 1-cycle grant-to-owner latency with HREADY held high.

Simultaneous events:
- A request rising in the same cycle as arb_en is eligible.
- A request dropping mid-burst does not remove the grant until the burst ends.
- HREADY low on the final beat delays re-arbitration until HREADY rises.

Invariant: HGRANT is exactly one-hot at all times.

Test Plan:
- Reset, no requests -> HGRANT = 0001, HMASTER = 0, HMASTLOCK = 0; holds for 10 cycles.
- HBUSREQ = 0011, M0 issues INCR4 with HREADY = 1 -> HGRANT stays 0001 through 3 SEQ beats; becomes 0010 at the edge accepting beat 4; HMASTER = 1 one edge later.
- INCR8 with a BUSY after beat 2 and HREADY low 2 cycles on beat 5 -> cnt sequence 7,6,6,5,4,4,4,3..0; grant change only after beat 8 is accepted.
- All 4 masters request SINGLE continuously -> grant order 1,2,3,0,1,... one change per HREADY edge.
- M2 asserts HLOCK with two back-to-back INCR4, others requesting -> HGRANT = 0100 across both bursts; HMASTLOCK = 1; after HLOCK drops, next grant goes to M3.
- M1 aborts INCR16 with IDLE after 5 beats -> cnt = 0; arbitration occurs at that edge; HRESETn pulsed low mid-burst -> outputs return immediately (asynchronously) to their reset values.
